// File: rtl/noc_pkg.sv
// Shared types and defaults for the NoC virtual-channel output port.
// Sizing helper keeps VC index width at least one bit for single-VC builds.
package noc_pkg;

  localparam int NOC_WIDTH   = 16;
  localparam int NOC_DEPTH   = 5;
  localparam int NOC_NUM_VC  = 2;
  localparam int NOC_CREDITS = 5;

  localparam int ERR_CREDIT_OVF = 0;
  localparam int ERR_PUSH_FULL  = 1;

  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  localparam int NOC_VCW = vc_width(NOC_NUM_VC);

  typedef logic [NOC_WIDTH-1:0] flit_t;
  typedef logic [NOC_VCW-1:0]   vc_id_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Per-VC flit FIFO: head visible combinationally, push lands in storage on the edge (no bypass).
// Push while full and pop while empty are ignored; pointers wrap at DEPTH, any DEPTH >= 2.
module noc_vc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == MAX_CNT);
  assign empty   = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves occupancy untouched.
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/noc_vc_output_port.sv
// Credit-based NoC output port: per-VC FIFOs, round-robin VC grant, one registered flit/cycle, 1-edge min latency.
// Backpressure via per-VC full (drops + sticky err) and downstream credits; NOC_OUTPORT_STATS_EN adds counters.
module noc_vc_output_port
  import noc_pkg::*;
#(
  parameter int  WIDTH   = NOC_WIDTH,
  parameter int  DEPTH   = NOC_DEPTH,
  parameter int  NUM_VC  = NOC_NUM_VC,
  parameter int  CREDITS = NOC_CREDITS,
  localparam int VCW     = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [VCW-1:0]    vc_i,
  input  logic              port_en,
  input  logic [NUM_VC-1:0] inc_credit_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [VCW-1:0]    vc_o,
  output logic              send_data,
  output logic [NUM_VC-1:0] full,
  output logic [1:0]        err_o
`ifdef NOC_OUTPORT_STATS_EN
  ,
  output logic [NUM_VC-1:0][31:0] stat_flits_o,
  output logic [NUM_VC-1:0][31:0] stat_stall_o
`endif
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW:0]   CRED_MAX  = (CW + 1)'(CREDITS);
  localparam logic [CW-1:0] CRED_INIT = CW'(CREDITS);

  logic [NUM_VC-1:0]             vc_sel, push_v, empty_v, elig, gnt_oh;
  logic [NUM_VC-1:0][WIDTH-1:0]  head_v;
  logic [NUM_VC-1:0][CW-1:0]     credit_q, credit_d;
  logic [CW:0]                   cred_sum;
  logic [VCW-1:0]                rr_q, rr_d, gnt_idx;
  logic                          gnt_vld, push_full;
  logic [WIDTH-1:0]              data_q, data_d;
  logic [VCW-1:0]                vc_q, vc_d;
  logic                          send_q, send_d;
  logic [1:0]                    err_q, err_d;
`ifdef NOC_OUTPORT_STATS_EN
  logic [NUM_VC-1:0][31:0]       flits_q, flits_d, stall_q, stall_d;
`endif

  // A vc_i beyond NUM_VC-1 selects no FIFO and is silently ignored.
  always_comb begin
    vc_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (vc_i == VCW'(v)) begin
        vc_sel[v] = 1'b1;
      end
    end
  end

  assign push_v    = (port_en ? vc_sel : '0) & ~full;
  assign push_full = port_en && |(vc_sel & full);

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    noc_vc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_v[g]),
      .pop    (gnt_oh[g]),
      .data_i (data_i),
      .head_o (head_v[g]),
      .full   (full[g]),
      .empty  (empty_v[g])
    );
    assign elig[g] = !empty_v[g] && (credit_q[g] != '0);
  end

  // Round robin: first pass scans from the pointer upward, second pass wraps from VC 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (!gnt_vld && elig[v] && (VCW'(v) >= rr_q)) begin
        gnt_vld   = 1'b1;
        gnt_idx   = VCW'(v);
        gnt_oh[v] = 1'b1;
      end
    end
    for (int v = 0; v < NUM_VC; v++) begin
      if (!gnt_vld && elig[v]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = VCW'(v);
        gnt_oh[v] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d   = rr_q;
    data_d = data_q;
    vc_d   = vc_q;
    send_d = gnt_vld;
    if (gnt_vld) begin
      rr_d = (gnt_idx == VCW'(NUM_VC - 1)) ? '0 : gnt_idx + 1'b1;
      vc_d = gnt_idx;
      for (int v = 0; v < NUM_VC; v++) begin
        if (gnt_oh[v]) begin
          data_d = head_v[v];
        end
      end
    end
  end

  // Grants only happen with credit != 0, so the sum cannot underflow.
  always_comb begin
    err_d    = err_q;
    credit_d = credit_q;
    cred_sum = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_sum = {1'b0, credit_q[v]} + (CW + 1)'(inc_credit_i[v]) - (CW + 1)'(gnt_oh[v]);
      if (cred_sum > CRED_MAX) begin
        credit_d[v]           = CRED_INIT;
        err_d[ERR_CREDIT_OVF] = 1'b1;
      end else begin
        credit_d[v] = cred_sum[CW-1:0];
      end
    end
    if (push_full) begin
      err_d[ERR_PUSH_FULL] = 1'b1;
    end
  end

`ifdef NOC_OUTPORT_STATS_EN
  always_comb begin
    flits_d = flits_q;
    stall_d = stall_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (gnt_oh[v]) begin
        flits_d[v] = flits_q[v] + 32'd1;
      end
      if (!empty_v[v] && (credit_q[v] == '0)) begin
        stall_d[v] = stall_q[v] + 32'd1;
      end
    end
  end

  assign stat_flits_o = flits_q;
  assign stat_stall_o = stall_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= CRED_INIT;
      end
      rr_q   <= '0;
      data_q <= '0;
      vc_q   <= '0;
      send_q <= 1'b0;
      err_q  <= '0;
`ifdef NOC_OUTPORT_STATS_EN
      flits_q <= '0;
      stall_q <= '0;
`endif
    end else begin
      credit_q <= credit_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      vc_q     <= vc_d;
      send_q   <= send_d;
      err_q    <= err_d;
`ifdef NOC_OUTPORT_STATS_EN
      flits_q <= flits_d;
      stall_q <= stall_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign vc_o      = vc_q;
  assign send_data = send_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_noc_vc_output_port.sv
// Bench for noc_vc_output_port: queue-based reference model, per-cycle compare, directed and random phases.
module tb_noc_vc_output_port;

  localparam int W  = 16;
  localparam int D  = 5;
  localparam int N  = 2;
  localparam int C  = 5;
  localparam int VW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [VW-1:0] vc_i = '0;
  logic          port_en = 1'b0;
  logic [N-1:0]  inc_credit_i = '0;
  logic [W-1:0]  data_o;
  logic [VW-1:0] vc_o;
  logic          send_data;
  logic [N-1:0]  full;
  logic [1:0]    err_o;
`ifdef NOC_OUTPORT_STATS_EN
  logic [N-1:0][31:0] stat_flits_o, stat_stall_o;
`endif

  always #5 clk = ~clk;

  noc_vc_output_port #(.WIDTH(W), .DEPTH(D), .NUM_VC(N), .CREDITS(C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .vc_i         (vc_i),
    .port_en      (port_en),
    .inc_credit_i (inc_credit_i),
    .data_o       (data_o),
    .vc_o         (vc_o),
    .send_data    (send_data),
    .full         (full),
    .err_o        (err_o)
`ifdef NOC_OUTPORT_STATS_EN
    ,
    .stat_flits_o (stat_flits_o),
    .stat_stall_o (stat_stall_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: plain queues, integer credits and pointer.
  logic [W-1:0]  q[N][$];
  int            cred[N];
  int            rr;
  logic [1:0]    m_err;
  int            m_flits[N];
  int            m_stall[N];
  logic [W-1:0]  nx_data, e_data;
  logic [VW-1:0] nx_vc, e_vc;
  logic          nx_send, e_send;
  logic [N-1:0]  nx_full, e_full;
  logic [1:0]    nx_err, e_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      q[v].delete();
      cred[v]    = C;
      m_flits[v] = 0;
      m_stall[v] = 0;
    end
    rr = 0;
    m_err = '0;
    nx_data = '0; nx_vc = '0; nx_send = 1'b0; nx_full = '0; nx_err = '0;
    e_data  = '0; e_vc  = '0; e_send  = 1'b0; e_full  = '0; e_err  = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] full_pre;
    int g;
    int c;
    for (int v = 0; v < N; v++) begin
      full_pre[v] = (q[v].size() == D);
      if (q[v].size() > 0 && cred[v] == 0) m_stall[v]++;
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      int v;
      v = (rr + i) % N;
      if (g < 0 && q[v].size() > 0 && cred[v] > 0) g = v;
    end
    nx_send = (g >= 0);
    if (g >= 0) begin
      nx_data = q[g].pop_front();
      nx_vc   = g[VW-1:0];
      cred[g]--;
      m_flits[g]++;
      rr = (g + 1) % N;
    end
    if (port_en && int'(vc_i) < N) begin
      if (full_pre[vc_i]) m_err[1] = 1'b1;
      else q[vc_i].push_back(data_i);
    end
    for (int v = 0; v < N; v++) begin
      c = cred[v] + int'(inc_credit_i[v]);
      if (c > C) begin
        c = C;
        m_err[0] = 1'b1;
      end
      cred[v] = c;
      nx_full[v] = (q[v].size() == D);
    end
    nx_err = m_err;
  endtask

  task automatic step(input bit en, input int vc, input logic [W-1:0] d, input logic [N-1:0] inc);
    port_en      = en;
    vc_i         = vc[VW-1:0];
    data_i       = d;
    inc_credit_i = inc;
    model_step();
    @(posedge clk);
    #1;
    e_data = nx_data; e_vc = nx_vc; e_send = nx_send; e_full = nx_full; e_err = nx_err;
  endtask

  task automatic do_reset(input string tag);
    port_en = 1'b0; inc_credit_i = '0;
    rst_n = 1'b0;
    #1;
    check({tag, "_send"}, 64'(send_data), 64'd0);
    check({tag, "_data"}, 64'(data_o), 64'd0);
    check({tag, "_vc"},   64'(vc_o), 64'd0);
    check({tag, "_err"},  64'(err_o), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_send", 64'(send_data), 64'(e_send));
      check("cyc_data", 64'(data_o), 64'(e_data));
      check("cyc_vc",   64'(vc_o), 64'(e_vc));
      check("cyc_full", 64'(full), 64'(e_full));
      check("cyc_err",  64'(err_o), 64'(e_err));
`ifdef NOC_OUTPORT_STATS_EN
      for (int v = 0; v < N; v++) begin
        check("cyc_stat_flits", 64'(stat_flits_o[v]), 64'(m_flits[v]));
        check("cyc_stat_stall", 64'(stat_stall_o[v]), 64'(m_stall[v]));
      end
`endif
    end
  end

  initial begin
    int sends;
    logic full0_seen;
    logic [3:0] seq;
    model_reset();
    #2;
    check("rst_send", 64'(send_data), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_err",  64'(err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Single flit: no bypass, visible one edge after the push edge.
    step(1'b1, 0, 16'hA5A5, 2'b00);
    check("a5_no_bypass", 64'(send_data), 64'd0);
    step(1'b0, 0, 16'h0000, 2'b00);
    check("a5_send", 64'(send_data), 64'd1);
    check("a5_data", 64'(data_o), 64'hA5A5);
    check("a5_vc",   64'(vc_o), 64'd0);

    // Six flits on VC0 with five credits: five go, sixth waits for a credit.
    do_reset("r1");
    sends = 0; full0_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 0, 16'h0100 + 16'(k), 2'b00);
      sends += int'(send_data); full0_seen |= full[0];
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 0, 16'h0000, 2'b00);
      sends += int'(send_data); full0_seen |= full[0];
    end
    check("six_sent_five", 64'(sends), 64'd5);
    check("six_full_never", 64'(full0_seen), 64'd0);
    step(1'b0, 0, 16'h0000, 2'b01);
    sends += int'(send_data);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, 16'h0000, 2'b00);
      sends += int'(send_data);
    end
    check("credit_one_more", 64'(sends), 64'd6);
    check("sixth_data", 64'(data_o), 64'h0105);

    // Both VCs loaded: alternating grants at full rate.
    do_reset("r2");
    seq = '0; sends = 0;
    step(1'b1, 0, 16'h00A0, 2'b00);
    step(1'b1, 1, 16'h00B0, 2'b00);
    seq = {seq[2:0], vc_o[0]}; sends += int'(send_data);
    step(1'b1, 0, 16'h00A1, 2'b00);
    seq = {seq[2:0], vc_o[0]}; sends += int'(send_data);
    step(1'b1, 1, 16'h00B1, 2'b00);
    seq = {seq[2:0], vc_o[0]}; sends += int'(send_data);
    step(1'b0, 0, 16'h0000, 2'b00);
    seq = {seq[2:0], vc_o[0]}; sends += int'(send_data);
    check("alt_vc_seq", 64'(seq), 64'b0101);
    check("alt_sends", 64'(sends), 64'd4);

    // VC1 credits exhausted then filled to DEPTH; extra push is dropped.
    do_reset("r3");
    for (int k = 0; k < 10; k++) step(1'b1, 1, 16'h0200 + 16'(k), 2'b00);
    step(1'b0, 0, 16'h0000, 2'b00);
    check("vc1_full", 64'(full), 64'b10);
    step(1'b1, 1, 16'hDEAD, 2'b00);
    check("vc1_drop_err", 64'(err_o), 64'b10);
    check("vc1_still_full", 64'(full), 64'b10);

    // Credit return at maximum saturates and flags; async reset mid-stream clears.
    do_reset("r4");
    step(1'b0, 0, 16'h0000, 2'b01);
    check("cred_ovf_err", 64'(err_o), 64'b01);
    step(1'b1, 1, 16'h7777, 2'b00);
    step(1'b1, 0, 16'h8888, 2'b00);
    check("pre_rst_send", 64'(send_data), 64'd1);
    do_reset("r5");

    // Random traffic with varying credit return rates.
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] inc;
      int shift;
      shift = ((k / 500) % 2 == 0) ? 2 : 4;
      for (int v = 0; v < N; v++) inc[v] = ($urandom % (1 << shift)) == 0;
      step(($urandom % 4) != 0, int'($urandom % N), 16'($urandom), inc);
      if ($urandom % 700 == 0) do_reset("rnd_rst");
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
